stream_arb2: RTL and testbench
==============================

Name: stream_arb2

Overview:
- Two-requester round-robin arbiter that shares one 2:1 datapath mux and one output channel between two valid/ready input streams.
- Packet-aware: once a requester wins, the grant is held until that requester's beat with last=1 is accepted.
- Output is registered, so there is a 1-cycle pipeline stage.
- Sits in front of any shared single-port consumer. It owns the mux select and sequences it per packet.

Parameters:
- NBITS, 8, width of the data payload on each stream.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active low.
- in0_val  input  1  requester 0 beat valid.
- in0_rdy  output  1  requester 0 beat accepted this cycle when in0_val && in0_rdy.
- in0_data  input  NBITS  requester 0 payload.
- in0_last  input  1  requester 0 final beat of packet.
- in1_val / in1_rdy / in1_data / in1_last: same as the requester 0 ports, for requester 1.
- out_val  output  1  output register holds a beat.
- out_rdy  input  1  consumer accepts when out_val && out_rdy.
- out_data  output  NBITS  registered payload.
- out_last  output  1  registered last flag.
- out_src  output  1  index of the requester that produced the registered beat.

Behaviour:
- Reset is asynchronous and active-low: clk is the single clock, rst_n the reset.
- While rst_n=0:
  - out_val=0, out_data=0, out_last=0, out_src=0.
  - FSM=IDLE, prio=0.
  - in0_rdy=in1_rdy=0.
- space = !out_val || out_rdy. A full register being drained accepts a new beat in the same cycle.
- FSM states: IDLE, LOCK0, LOCK1. prio is a 1-bit register naming the favoured requester in IDLE.
- IDLE:
  - Winner w is the valid requester. If both are valid, w = prio.
  - in_w_rdy = space. The loser's rdy = 0.
  - On accepted beat with last=1: stay IDLE, prio <= ~w.
  - On accepted beat with last=0: go to LOCKw, prio unchanged.
- LOCKx:
  - in_x_rdy = space. The other requester's rdy = 0 regardless of its valid.
  - On accepted beat with last=1: go to IDLE, prio <= ~x.
  - last=0 beats, or no transfer: stay in LOCKx.
- Select and data path:
  - Mux select = w in IDLE, x in LOCKx.
  - On accept: out_data <= mux(in0_data, in1_data, sel), out_last <= in_sel_last, out_src <= sel, out_val <= 1.
- Drain: if out_val && out_rdy and no new beat is accepted, out_val <= 0. out_data/out_last/out_src hold their stale values.
- Latency: a beat accepted at edge N is visible on out_* after edge N. Throughput is 1 beat/cycle with out_rdy held high.
- Ready paths: in*_rdy depend combinationally on in*_val (IDLE only), the FSM state and out_rdy. in*_val must not depend combinationally on in*_rdy.
- Protocol: a requester must hold val/data/last stable until accepted. The block does not check this.
- No valid inputs in IDLE: FSM and prio are unchanged.
- Fairness: with both requesters continuously streaming single-beat packets, grants alternate 0,1,0,1.
- Reset asserted mid-packet: lock is dropped, the buffered beat is discarded, and prio returns to 0. No partial-packet recovery.
- out_rdy=0 with a full register: no input is accepted and FSM/prio hold.

Decomposition:
- Shared package stream_arb_pkg:
  - typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} arb_state_t.
  - Constant REQ_W = 1, the requester index width.
- Sub-module mux2_nbits (parameter NBITS): combinational 2:1 data mux, instantiated once for the payload. last and src are muxed inline.
- Everything else (FSM, prio, output register) stays in stream_arb2.

Test Plan:
1. Reset: hold rst_n=0 with in0_val=in1_val=1 -> out_val=0, in0_rdy=in1_rdy=0. Release, out_rdy=1 -> first edge accepts requester 0 (prio=0); next cycle out_src=0.
2. Single-beat contention: both streams valid with last=1, in0_data=0xA0.., in1_data=0xB0.., out_rdy=1 for 6 cycles -> out_src sequence 0,1,0,1,0,1 with the matching data.
3. Packet lock: in0 sends a 3-beat packet (0x11, 0x12, 0x13 with last on beat 3) while in1_val=1 throughout -> in1_rdy=0 for those 3 cycles. Output is 0x11, 0x12, 0x13 with out_last only on 0x13; the next beat is from in1.
4. Backpressure: out_rdy=0 with out_val=1 for 4 cycles -> in*_rdy=0 and out_data stable. Raise out_rdy -> same-cycle refill, no bubble, no duplicate.
5. Idle/prio hold: in1 single beat, then 3 idle cycles, then both valid -> in0 wins (prio=0 after in1 served).
6. Reset mid-packet: assert rst_n=0 asynchronously while in LOCK1 after beat 1 of 3 -> out_val drops immediately. After release, with both valid, in0 is granted first.

Source files
------------

// File: rtl/stream_arb2_pkg.sv
//------------------------------------------------------------------------------
// Module : stream_arb_pkg
// Brief  : Shared types and constants for the two-requester stream arbiter.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package stream_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } arb_state_t;

   localparam int REQ_W = 1;

endpackage

`default_nettype wire

// File: rtl/stream_arb2_if.sv
//------------------------------------------------------------------------------
// Module : stream_arb2_if
// Brief  : Two input streams plus one output stream of the arbiter.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface stream_arb2_if #(
   parameter int NBITS = 8
);
   import stream_arb_pkg::*;

   logic             in0_val;
   logic             in0_rdy;
   logic [NBITS-1:0] in0_data;
   logic             in0_last;
   logic             in1_val;
   logic             in1_rdy;
   logic [NBITS-1:0] in1_data;
   logic             in1_last;
   logic             out_val;
   logic             out_rdy;
   logic [NBITS-1:0] out_data;
   logic             out_last;
   logic [REQ_W-1:0] out_src;

   // master = producers/consumer around the arbiter, slave = the arbiter
   modport master (
      output in0_val, in0_data, in0_last,
      output in1_val, in1_data, in1_last,
      output out_rdy,
      input  in0_rdy, in1_rdy,
      input  out_val, out_data, out_last, out_src
   );

   modport slave (
      input  in0_val, in0_data, in0_last,
      input  in1_val, in1_data, in1_last,
      input  out_rdy,
      output in0_rdy, in1_rdy,
      output out_val, out_data, out_last, out_src
   );

endinterface

`default_nettype wire

// File: rtl/stream_arb2_mux.sv
//------------------------------------------------------------------------------
// Module : mux2_nbits
// Brief  : Combinational 2:1 payload mux.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux2_nbits #(
   parameter int NBITS = 8
) (
   input  logic [NBITS-1:0] a_i,
   input  logic [NBITS-1:0] b_i,
   input  logic             sel_i,
   output logic [NBITS-1:0] y_o
);

   assign y_o = sel_i ? b_i : a_i;

endmodule

`default_nettype wire

// File: rtl/stream_arb2.sv
//------------------------------------------------------------------------------
// Module : stream_arb2
// Brief  : Packet-aware round-robin arbiter, two streams into one registered output.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stream_arb2
   import stream_arb_pkg::*;
#(
   parameter int NBITS = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   stream_arb2_if.slave bus
);

   arb_state_t       state_q, state_d;
   logic             prio_q, prio_d;
   logic             out_val_q;
   logic [NBITS-1:0] out_data_q;
   logic             out_last_q;
   logic [REQ_W-1:0] out_src_q;

   logic             space;
   logic             any_val;
   logic             win;
   logic             sel;
   logic             sel_rdy;
   logic             sel_val;
   logic             sel_last;
   logic             accept;
   logic [NBITS-1:0] mux_data;

   assign space   = !out_val_q || bus.out_rdy;
   assign any_val = bus.in0_val || bus.in1_val;
   assign win     = (bus.in0_val && bus.in1_val) ? prio_q : bus.in1_val;

   // Ready is held low while reset is asserted, even though it is combinational.
   always_comb begin
      sel     = win;
      sel_rdy = 1'b0;
      unique case (state_q)
         LOCK0: begin
            sel     = 1'b0;
            sel_rdy = space;
         end
         LOCK1: begin
            sel     = 1'b1;
            sel_rdy = space;
         end
         default: begin
            sel     = win;
            sel_rdy = space && any_val;
         end
      endcase
      sel_rdy = sel_rdy && rst_n;
   end

   assign sel_val     = sel ? bus.in1_val  : bus.in0_val;
   assign sel_last    = sel ? bus.in1_last : bus.in0_last;
   assign accept      = sel_val && sel_rdy;
   assign bus.in0_rdy = sel_rdy && !sel;
   assign bus.in1_rdy = sel_rdy && sel;

   mux2_nbits #(
      .NBITS (NBITS)
   ) u_mux (
      .a_i   (bus.in0_data),
      .b_i   (bus.in1_data),
      .sel_i (sel),
      .y_o   (mux_data)
   );

   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      if (accept) begin
         if (sel_last) begin
            state_d = IDLE;
            prio_d  = ~sel;
         end else if (state_q == IDLE) begin
            state_d = sel ? LOCK1 : LOCK0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         prio_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
      end
   end

   // A draining register refills in the same cycle; payload holds when emptied.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_val_q  <= 1'b0;
         out_data_q <= '0;
         out_last_q <= 1'b0;
         out_src_q  <= '0;
      end else if (accept) begin
         out_val_q  <= 1'b1;
         out_data_q <= mux_data;
         out_last_q <= sel_last;
         out_src_q  <= sel;
      end else if (bus.out_rdy) begin
         out_val_q  <= 1'b0;
      end
   end

   assign bus.out_val  = out_val_q;
   assign bus.out_data = out_data_q;
   assign bus.out_last = out_last_q;
   assign bus.out_src  = out_src_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_arb2.sv
//------------------------------------------------------------------------------
// Module : tb_stream_arb2
// Brief  : Directed, table-driven self-checking bench for stream_arb2.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_stream_arb2;

   logic clk;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   stream_arb2_if #(.NBITS(8)) bus ();

   stream_arb2 #(
      .NBITS (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       v0;
      logic [7:0] d0;
      logic       l0;
      logic       v1;
      logic [7:0] d1;
      logic       l1;
      logic       ordy;
      logic       er0;
      logic       er1;
      logic       eval;
      logic [7:0] edata;
      logic       elast;
      logic       esrc;
   } vec_t;

   localparam int NV = 22;
   vec_t vt [NV];

   function automatic vec_t mk(input logic v0, input logic [7:0] d0, input logic l0,
                               input logic v1, input logic [7:0] d1, input logic l1,
                               input logic ordy, input logic er0, input logic er1,
                               input logic eval, input logic [7:0] edata,
                               input logic elast, input logic esrc);
      vec_t v;
      v.v0 = v0; v.d0 = d0; v.l0 = l0;
      v.v1 = v1; v.d1 = d1; v.l1 = l1;
      v.ordy = ordy; v.er0 = er0; v.er1 = er1;
      v.eval = eval; v.edata = edata; v.elast = elast; v.esrc = esrc;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [7:0] act,
                      input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step%0d: got %h, want %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic v0, input logic [7:0] d0, input logic l0,
                        input logic v1, input logic [7:0] d1, input logic l1,
                        input logic ordy);
      bus.in0_val = v0; bus.in0_data = d0; bus.in0_last = l0;
      bus.in1_val = v1; bus.in1_data = d1; bus.in1_last = l1;
      bus.out_rdy = ordy;
   endtask

   initial begin
      //            in0          in1          ordy rdy0 rdy1 oval odata olast osrc
      // round-robin single-beat contention
      vt[0]  = mk(1,8'hA0,1, 1,8'hB0,1, 1,  1,0, 1,8'hA0,1,0);
      vt[1]  = mk(1,8'hA1,1, 1,8'hB0,1, 1,  0,1, 1,8'hB0,1,1);
      vt[2]  = mk(1,8'hA1,1, 1,8'hB1,1, 1,  1,0, 1,8'hA1,1,0);
      vt[3]  = mk(1,8'hA2,1, 1,8'hB1,1, 1,  0,1, 1,8'hB1,1,1);
      vt[4]  = mk(1,8'hA2,1, 1,8'hB2,1, 1,  1,0, 1,8'hA2,1,0);
      vt[5]  = mk(1,8'hA3,1, 1,8'hB2,1, 1,  0,1, 1,8'hB2,1,1);
      // in0 three-beat packet locks out in1
      vt[6]  = mk(1,8'h11,0, 1,8'hC0,1, 1,  1,0, 1,8'h11,0,0);
      vt[7]  = mk(1,8'h12,0, 1,8'hC0,1, 1,  1,0, 1,8'h12,0,0);
      vt[8]  = mk(1,8'h13,1, 1,8'hC0,1, 1,  1,0, 1,8'h13,1,0);
      vt[9]  = mk(1,8'hD0,1, 1,8'hC0,1, 1,  0,1, 1,8'hC0,1,1);
      // backpressure then same-cycle refill, then drain
      vt[10] = mk(1,8'hD0,1, 0,8'h00,0, 0,  0,0, 1,8'hC0,1,1);
      vt[11] = mk(1,8'hD0,1, 0,8'h00,0, 0,  0,0, 1,8'hC0,1,1);
      vt[12] = mk(1,8'hD0,1, 0,8'h00,0, 0,  0,0, 1,8'hC0,1,1);
      vt[13] = mk(1,8'hD0,1, 0,8'h00,0, 0,  0,0, 1,8'hC0,1,1);
      vt[14] = mk(1,8'hD0,1, 0,8'h00,0, 1,  1,0, 1,8'hD0,1,0);
      vt[15] = mk(0,8'h00,0, 0,8'h00,0, 1,  0,0, 0,8'hD0,1,0);
      // in1 single beat, idle gap, then in0 wins
      vt[16] = mk(0,8'h00,0, 1,8'hE0,1, 1,  0,1, 1,8'hE0,1,1);
      vt[17] = mk(0,8'h00,0, 0,8'h00,0, 1,  0,0, 0,8'hE0,1,1);
      vt[18] = mk(0,8'h00,0, 0,8'h00,0, 1,  0,0, 0,8'hE0,1,1);
      vt[19] = mk(0,8'h00,0, 0,8'h00,0, 1,  0,0, 0,8'hE0,1,1);
      vt[20] = mk(1,8'hF0,1, 1,8'hF1,1, 1,  1,0, 1,8'hF0,1,0);
      // in1 starts a packet: beat 1 of 3
      vt[21] = mk(0,8'h00,0, 1,8'h60,0, 1,  0,1, 1,8'h60,0,1);

      rst_n = 1'b0;
      drive(1, 8'hA0, 1, 1, 8'hB0, 1, 1);
      #3;
      chk("rst_rdy0",  -1, bus.in0_rdy, 1'b0);
      chk("rst_rdy1",  -1, bus.in1_rdy, 1'b0);
      chk("rst_val",   -1, bus.out_val, 1'b0);
      chk("rst_data",  -1, bus.out_data, 8'h00);
      chk("rst_last",  -1, bus.out_last, 1'b0);
      chk("rst_src",   -1, bus.out_src, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_hold_val", -1, bus.out_val, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(vt[i].v0, vt[i].d0, vt[i].l0, vt[i].v1, vt[i].d1, vt[i].l1, vt[i].ordy);
         #2;
         chk("in0_rdy", i, bus.in0_rdy, vt[i].er0);
         chk("in1_rdy", i, bus.in1_rdy, vt[i].er1);
         @(posedge clk);
         #1;
         chk("out_val",  i, bus.out_val,  vt[i].eval);
         chk("out_data", i, bus.out_data, vt[i].edata);
         chk("out_last", i, bus.out_last, vt[i].elast);
         chk("out_src",  i, bus.out_src,  vt[i].esrc);
      end

      // LOCK1 must still hold off in0, then an asynchronous reset drops everything
      drive(1, 8'h70, 1, 1, 8'h61, 0, 1);
      #2;
      chk("lock1_rdy0", 100, bus.in0_rdy, 1'b0);
      chk("lock1_rdy1", 100, bus.in1_rdy, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_val",  101, bus.out_val, 1'b0);
      chk("arst_data", 101, bus.out_data, 8'h00);
      chk("arst_rdy0", 101, bus.in0_rdy, 1'b0);
      chk("arst_rdy1", 101, bus.in1_rdy, 1'b0);
      #1;
      rst_n = 1'b1;
      #1;
      chk("post_rst_rdy0", 102, bus.in0_rdy, 1'b1);
      chk("post_rst_rdy1", 102, bus.in1_rdy, 1'b0);
      @(posedge clk);
      #1;
      chk("post_rst_val",  103, bus.out_val, 1'b1);
      chk("post_rst_data", 103, bus.out_data, 8'h70);
      chk("post_rst_src",  103, bus.out_src, 1'b0);
      chk("post_rst_last", 103, bus.out_last, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
